// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates two write-back ports onto the single register
// file write port and tracks pending writes for RAW/WAW hazard detection.
module regfile_wb_ctrl (
  input  logic        clk,
  input  logic        clr,
  input  logic        iss_valid,
  input  logic [4:0]  iss_wn,
  output logic        iss_ready,
  input  logic        a_valid,
  input  logic [4:0]  a_wn,
  input  logic [31:0] a_d,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_wn,
  input  logic [31:0] b_d,
  output logic        b_ready,
  output logic        rf_we,
  output logic [4:0]  rf_wn,
  output logic [31:0] rf_d,
  input  logic [4:0]  rna,
  input  logic [4:0]  rnb,
  output logic        haz_a,
  output logic        haz_b,
  output logic [5:0]  pend_cnt,
  output logic        err
);

  typedef enum logic {PORT_A = 1'b0, PORT_B = 1'b1} port_e;

  // Bit 0 exists only so the array can be indexed by any register number; it never sets.
  logic [31:0] pending;
  logic [31:0] pending_nxt;
  logic [31:0] set_mask;
  logic [31:0] clr_mask;
  logic [5:0]  cnt_nxt;
  port_e       last;

  logic        a_full;
  logic [4:0]  a_hold_wn;
  logic [31:0] a_hold_d;
  logic        b_full;
  logic [4:0]  b_hold_wn;
  logic [31:0] b_hold_d;

  logic        grant_a;
  logic        grant_b;
  logic        grant_any;
  logic [4:0]  g_wn;
  logic [31:0] g_d;
  logic        a_hs;
  logic        b_hs;
  logic        iss_set;
  logic        commit_hit;
  logic        commit_err;

  // Reset suppresses the grant so a discarded entry never reaches the register file.
  always_comb begin
    grant_a   = ~clr & a_full & (~b_full | (last == PORT_B));
    grant_b   = ~clr & b_full & (~a_full | (last == PORT_A));
    grant_any = grant_a | grant_b;
    g_wn      = '0;
    g_d       = '0;
    if (grant_a) begin
      g_wn = a_hold_wn;
      g_d  = a_hold_d;
    end else if (grant_b) begin
      g_wn = b_hold_wn;
      g_d  = b_hold_d;
    end
  end

  assign rf_we = grant_any & (g_wn != 5'd0);
  assign rf_wn = g_wn;
  assign rf_d  = g_d;

  assign a_ready = ~a_full | grant_a;
  assign b_ready = ~b_full | grant_b;
  assign a_hs    = a_valid & a_ready;
  assign b_hs    = b_valid & b_ready;

  assign iss_ready  = (iss_wn == 5'd0) | ~pending[iss_wn];
  assign iss_set    = iss_valid & iss_ready & (iss_wn != 5'd0);
  assign commit_hit = rf_we & pending[g_wn];
  assign commit_err = rf_we & ~pending[g_wn];

  assign haz_a = (rna != 5'd0) & pending[rna];
  assign haz_b = (rnb != 5'd0) & pending[rnb];

  // An issue and a commit on the same register cannot both take effect: a pending
  // register blocks issue, so the clear only ever hits bits that are already set.
  always_comb begin
    set_mask    = iss_set ? (32'd1 << iss_wn) : 32'd0;
    clr_mask    = commit_hit ? (32'd1 << g_wn) : 32'd0;
    pending_nxt = ((pending & ~clr_mask) | set_mask) & ~32'd1;
    cnt_nxt     = pend_cnt + {5'd0, iss_set} - {5'd0, commit_hit};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk) begin
    if (clr) begin
      pending  <= '0;
      pend_cnt <= '0;
      err      <= 1'b0;
      last     <= PORT_B;
      a_full   <= 1'b0;
      b_full   <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= cnt_nxt;
      if (commit_err)
        err <= 1'b1;
      if (grant_a)
        last <= PORT_A;
      else if (grant_b)
        last <= PORT_B;
      a_full <= a_hs | (a_full & ~grant_a);
      b_full <= b_hs | (b_full & ~grant_b);
    end
  end

  // NOTE: holding payloads are not reset; the full flags alone say whether they
  // are meaningful, so resetting the data would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (a_hs) begin
      a_hold_wn <= a_wn;
      a_hold_d  <= a_d;
    end
    if (b_hs) begin
      b_hold_wn <= b_wn;
      b_hold_d  <= b_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: a write scoreboard checked by a monitor
// plus one task per scenario with inline checks.
module tb_regfile_wb_ctrl;

  typedef struct packed {
    logic [4:0]  wn;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        iss_valid;
  logic [4:0]  iss_wn;
  logic        iss_ready;
  logic        a_valid;
  logic [4:0]  a_wn;
  logic [31:0] a_d;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_wn;
  logic [31:0] b_d;
  logic        b_ready;
  logic        rf_we;
  logic [4:0]  rf_wn;
  logic [31:0] rf_d;
  logic [4:0]  rna;
  logic [4:0]  rnb;
  logic        haz_a;
  logic        haz_b;
  logic [5:0]  pend_cnt;
  logic        err;

  int  errors = 0;
  int  checks = 0;
  wr_t exp_q[$];

  regfile_wb_ctrl dut (
    .clk(clk), .clr(clr),
    .iss_valid(iss_valid), .iss_wn(iss_wn), .iss_ready(iss_ready),
    .a_valid(a_valid), .a_wn(a_wn), .a_d(a_d), .a_ready(a_ready),
    .b_valid(b_valid), .b_wn(b_wn), .b_d(b_d), .b_ready(b_ready),
    .rf_we(rf_we), .rf_wn(rf_wn), .rf_d(rf_d),
    .rna(rna), .rnb(rnb), .haz_a(haz_a), .haz_b(haz_b),
    .pend_cnt(pend_cnt), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every register file write must match the oldest expected write.
  always @(negedge clk) begin
    if (rf_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got wn=%0d d=%h, required no write", rf_wn, rf_d);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if ({rf_wn, rf_d} !== e) begin
          errors++;
          $display("FAIL write_data: got wn=%0d d=%h, required wn=%0d d=%h", rf_wn, rf_d, e.wn, e.d);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic pulse_reset();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic do_issue(input logic [4:0] wn);
    iss_valid = 1'b1;
    iss_wn    = wn;
    step();
    iss_valid = 1'b0;
  endtask

  task automatic test_reset();
    pulse_reset();
    @(negedge clk);
    chk("reset_iss_ready", 32'(iss_ready), 32'd1);
    chk("reset_a_ready", 32'(a_ready), 32'd1);
    chk("reset_b_ready", 32'(b_ready), 32'd1);
    chk("reset_rf_we", 32'(rf_we), 32'd0);
    chk("reset_haz", 32'({haz_a, haz_b}), 32'd0);
    chk("reset_pend_cnt", 32'(pend_cnt), 32'd0);
    chk("reset_err", 32'(err), 32'd0);
    step();
  endtask

  task automatic test_single();
    rna = 5'd5;
    do_issue(5'd5);
    @(negedge clk);
    chk("single_haz_after_issue", 32'(haz_a), 32'd1);
    chk("single_cnt_after_issue", 32'(pend_cnt), 32'd1);
    step();
    a_valid = 1'b1; a_wn = 5'd5; a_d = 32'h1234;
    exp_q.push_back('{wn: 5'd5, d: 32'h1234});
    step();
    a_valid = 1'b0;
    @(negedge clk);
    chk("single_rf_we", 32'(rf_we), 32'd1);
    chk("single_haz_during_write", 32'(haz_a), 32'd1);
    step();
    @(negedge clk);
    chk("single_haz_after_commit", 32'(haz_a), 32'd0);
    chk("single_cnt_after_commit", 32'(pend_cnt), 32'd0);
    step();
  endtask

  // Tie between A (r3) and B (r4); b_first selects which port is expected to win.
  task automatic test_tie(input logic b_first, input logic [31:0] da, input logic [31:0] db);
    do_issue(5'd3);
    do_issue(5'd4);
    a_valid = 1'b1; a_wn = 5'd3; a_d = da;
    b_valid = 1'b1; b_wn = 5'd4; b_d = db;
    if (b_first) begin
      exp_q.push_back('{wn: 5'd4, d: db});
      exp_q.push_back('{wn: 5'd3, d: da});
    end else begin
      exp_q.push_back('{wn: 5'd3, d: da});
      exp_q.push_back('{wn: 5'd4, d: db});
    end
    @(negedge clk);
    chk("tie_both_ready", 32'({a_ready, b_ready}), 32'd3);
    step();
    a_valid = 1'b0;
    b_valid = 1'b0;
    @(negedge clk);
    chk("tie_first_wn", 32'(rf_wn), b_first ? 32'd4 : 32'd3);
    chk("tie_loser_stalled", 32'({a_ready, b_ready}), b_first ? 32'd1 : 32'd2);
    step();
    @(negedge clk);
    chk("tie_second_wn", 32'(rf_wn), b_first ? 32'd3 : 32'd4);
    chk("tie_second_we", 32'(rf_we), 32'd1);
    step();
    @(negedge clk);
    chk("tie_idle_we", 32'(rf_we), 32'd0);
    chk("tie_cnt", 32'(pend_cnt), 32'd0);
    step();
  endtask

  task automatic test_r0();
    a_valid = 1'b1; a_wn = 5'd0; a_d = 32'hFFFF;
    @(negedge clk);
    chk("r0_a_ready_accept", 32'(a_ready), 32'd1);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    chk("r0_rf_we", 32'(rf_we), 32'd0);
    chk("r0_a_ready_consume", 32'(a_ready), 32'd1);
    chk("r0_cnt", 32'(pend_cnt), 32'd0);
    chk("r0_err", 32'(err), 32'd0);
    step();
  endtask

  task automatic test_waw();
    do_issue(5'd7);
    iss_valid = 1'b1; iss_wn = 5'd7;
    a_valid = 1'b1; a_wn = 5'd7; a_d = 32'h77;
    exp_q.push_back('{wn: 5'd7, d: 32'h77});
    @(negedge clk);
    chk("waw_blocked", 32'(iss_ready), 32'd0);
    step();
    a_valid = 1'b0;
    @(negedge clk);
    chk("waw_blocked_commit_cycle", 32'(iss_ready), 32'd0);
    chk("waw_commit_we", 32'(rf_we), 32'd1);
    step();
    @(negedge clk);
    chk("waw_ready_after_commit", 32'(iss_ready), 32'd1);
    step();
    iss_valid = 1'b0;
    @(negedge clk);
    chk("waw_reissued_cnt", 32'(pend_cnt), 32'd1);
    chk("waw_reissued_pending", 32'(iss_ready), 32'd0);
    step();
    a_valid = 1'b1; a_wn = 5'd7; a_d = 32'h78;
    exp_q.push_back('{wn: 5'd7, d: 32'h78});
    step();
    a_valid = 1'b0;
    step();
    @(negedge clk);
    chk("waw_final_cnt", 32'(pend_cnt), 32'd0);
    chk("waw_err", 32'(err), 32'd0);
    step();
  endtask

  task automatic test_err();
    b_valid = 1'b1; b_wn = 5'd9; b_d = 32'h99;
    exp_q.push_back('{wn: 5'd9, d: 32'h99});
    step();
    b_valid = 1'b0;
    @(negedge clk);
    chk("err_write_we", 32'(rf_we), 32'd1);
    chk("err_before_commit", 32'(err), 32'd0);
    step();
    @(negedge clk);
    chk("err_set", 32'(err), 32'd1);
    chk("err_cnt", 32'(pend_cnt), 32'd0);
    step();
    step();
    @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    step();
  endtask

  task automatic test_flush();
    rna = 5'd1;
    rnb = 5'd2;
    do_issue(5'd1);
    do_issue(5'd2);
    a_valid = 1'b1; a_wn = 5'd1; a_d = 32'h11;
    step();
    a_valid = 1'b0;
    clr = 1'b1;
    @(negedge clk);
    chk("flush_no_write_in_reset", 32'(rf_we), 32'd0);
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("flush_cnt", 32'(pend_cnt), 32'd0);
    chk("flush_rf_we", 32'(rf_we), 32'd0);
    chk("flush_haz", 32'({haz_a, haz_b}), 32'd0);
    chk("flush_err_cleared", 32'(err), 32'd0);
    chk("flush_a_ready", 32'(a_ready), 32'd1);
    step();
    @(negedge clk);
    chk("flush_still_no_write", 32'(rf_we), 32'd0);
    step();
  endtask

  // Both ports stream four writes each; grants must alternate A, B, A, B.
  task automatic test_back_to_back();
    int ai = 0;
    int bi = 0;
    int cyc = 0;
    logic ahs;
    logic bhs;
    for (int r = 10; r < 18; r++)
      do_issue(5'(r));
    while ((ai < 4 || bi < 4) && cyc < 40) begin
      a_valid = (ai < 4); a_wn = 5'(10 + ai); a_d = 32'hA000 + 32'(ai);
      b_valid = (bi < 4); b_wn = 5'(14 + bi); b_d = 32'hB000 + 32'(bi);
      @(negedge clk);
      ahs = a_valid & a_ready;
      bhs = b_valid & b_ready;
      if (cyc > 0) begin
        checks++;
        if (ahs && bhs && (ai < 4) && (bi < 4)) begin
          errors++;
          $display("FAIL stream_single_accept: got both ports accepted in cycle %0d, required one", cyc);
        end
      end
      if (ahs) exp_q.push_back('{wn: a_wn, d: a_d});
      if (bhs) exp_q.push_back('{wn: b_wn, d: b_d});
      step();
      if (ahs) ai++;
      if (bhs) bi++;
      cyc++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    checks++;
    if (ai != 4 || bi != 4) begin
      errors++;
      $display("FAIL stream_timeout: got a=%0d b=%0d accepted, required 4 and 4", ai, bi);
    end
    repeat (3) step();
    @(negedge clk);
    chk("stream_cnt", 32'(pend_cnt), 32'd0);
    chk("stream_err", 32'(err), 32'd0);
    step();
  endtask

  initial begin
    clr = 1'b1;
    iss_valid = 1'b0; iss_wn = '0;
    a_valid = 1'b0; a_wn = '0; a_d = '0;
    b_valid = 1'b0; b_wn = '0; b_d = '0;
    rna = '0; rnb = '0;
    step();
    test_reset();
    test_single();
    pulse_reset();
    test_tie(1'b0, 32'hA, 32'hB);
    test_r0();
    test_tie(1'b1, 32'hA2, 32'hB2);
    test_waw();
    test_err();
    test_flush();
    test_back_to_back();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
